// File: rtl/operand_fifo.sv
// Operand FIFO on the adder datapath: loader pushes, controller pops via fifo_read.
// Define OPERAND_FIFO_ALMOST_FLAGS_EN to add registered almost_full/almost_empty outputs.
module operand_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   data_count,
   output logic              wr_ack,
   output logic              wr_err,
   output logic              rd_ack,
   output logic              rd_err,
`ifdef OPERAND_FIFO_ALMOST_FLAGS_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      NO_OP    = 3'd1,
      WRITE    = 3'd2,
      WR_ERROR = 3'd3,
      READ     = 3'd4,
      RD_ERROR = 3'd5,
      RDWR     = 3'd6
   } state_t;

   localparam logic [ADDR_W:0] LP_FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_AF_CNT   = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] LP_ONE_CNT  = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_full;
   logic              r_empty;
   logic              r_wr_ack;
   logic              r_wr_err;
   logic              r_rd_ack;
   logic              r_rd_err;
   state_t            r_state;

   state_t            w_state_nxt;
   logic              w_do_wr;
   logic              w_do_rd;
   logic              w_wr_rej;
   logic              w_rd_rej;
   logic [ADDR_W:0]   w_count_nxt;

   // Decision uses the registered full/empty from before the edge.
   always_comb begin
      w_state_nxt = NO_OP;
      w_do_wr     = 1'b0;
      w_do_rd     = 1'b0;
      w_wr_rej    = 1'b0;
      w_rd_rej    = 1'b0;
      case ({wr_en, rd_en})
         2'b10: begin
            if (r_full) begin
               w_state_nxt = WR_ERROR;
               w_wr_rej    = 1'b1;
            end else begin
               w_state_nxt = WRITE;
               w_do_wr     = 1'b1;
            end
         end
         2'b01: begin
            if (r_empty) begin
               w_state_nxt = RD_ERROR;
               w_rd_rej    = 1'b1;
            end else begin
               w_state_nxt = READ;
               w_do_rd     = 1'b1;
            end
         end
         2'b11: begin
            // Empty with both requests: push only, no bypass to rd_data.
            if (r_empty) begin
               w_state_nxt = WRITE;
               w_do_wr     = 1'b1;
               w_rd_rej    = 1'b1;
            end else begin
               w_state_nxt = RDWR;
               w_do_wr     = 1'b1;
               w_do_rd     = 1'b1;
            end
         end
         default: w_state_nxt = NO_OP;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_do_wr && !w_do_rd) w_count_nxt = r_count + LP_ONE_CNT;
      else if (w_do_rd && !w_do_wr) w_count_nxt = r_count - LP_ONE_CNT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= INIT;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rd_data <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_wr_ack  <= 1'b0;
         r_wr_err  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_rd_err  <= 1'b0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_do_rd) begin
            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            r_rd_data <= r_mem[r_rd_ptr];
         end
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == LP_FULL_CNT);
         r_empty  <= (w_count_nxt == '0);
         r_wr_ack <= w_do_wr;
         r_wr_err <= w_wr_rej;
         r_rd_ack <= w_do_rd;
         r_rd_err <= w_rd_rej;
      end
   end

`ifdef OPERAND_FIFO_ALMOST_FLAGS_EN
   logic r_almost_full;
   logic r_almost_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
      end else begin
         r_almost_full  <= (w_count_nxt >= LP_AF_CNT);
         r_almost_empty <= (w_count_nxt <= LP_ONE_CNT);
      end
   end

   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
`endif

   assign rd_data    = r_rd_data;
   assign full       = r_full;
   assign empty      = r_empty;
   assign data_count = r_count;
   assign wr_ack     = r_wr_ack;
   assign wr_err     = r_wr_err;
   assign rd_ack     = r_rd_ack;
   assign rd_err     = r_rd_err;
   assign state      = r_state;

endmodule

// File: tb/tb_operand_fifo.sv
// Bench for operand_fifo: directed steps plus random traffic checked against a queue model.
module tb_operand_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  localparam int S_INIT = 0, S_NO_OP = 1, S_WRITE = 2, S_WR_ERROR = 3;
  localparam int S_READ = 4, S_RD_ERROR = 5, S_RDWR = 6;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   data_count;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
  logic [2:0]        state;
`ifdef OPERAND_FIFO_ALMOST_FLAGS_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  operand_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
`ifdef OPERAND_FIFO_ALMOST_FLAGS_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .state      (state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_rd_data;
  int                exp_state;
  logic              exp_wr_ack, exp_wr_err, exp_rd_ack, exp_rd_err;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":rd_data"}, rd_data, exp_rd_data);
    chk({tag, ":count"}, 32'(data_count), 32'(exp_q.size()));
    chk({tag, ":full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, ":empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, ":wr_ack"}, 32'(wr_ack), 32'(exp_wr_ack));
    chk({tag, ":wr_err"}, 32'(wr_err), 32'(exp_wr_err));
    chk({tag, ":rd_ack"}, 32'(rd_ack), 32'(exp_rd_ack));
    chk({tag, ":rd_err"}, 32'(rd_err), 32'(exp_rd_err));
    chk({tag, ":state"}, 32'(state), 32'(exp_state));
`ifdef OPERAND_FIFO_ALMOST_FLAGS_EN
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(exp_q.size() >= DEPTH-1));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(exp_q.size() <= 1));
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rd_data = '0;
    exp_state   = S_INIT;
    exp_wr_ack  = 1'b0;
    exp_wr_err  = 1'b0;
    exp_rd_ack  = 1'b0;
    exp_rd_err  = 1'b0;
  endtask

  // driver: one clock of stimulus, model update, then check after the edge
  task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d, input string tag);
    int sz;
    @(negedge clk);
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    sz = exp_q.size();
    exp_wr_ack = 1'b0; exp_wr_err = 1'b0; exp_rd_ack = 1'b0; exp_rd_err = 1'b0;
    if (!wr && !rd) begin
      exp_state = S_NO_OP;
    end else if (wr && !rd) begin
      if (sz == DEPTH) begin
        exp_state = S_WR_ERROR; exp_wr_err = 1'b1;
      end else begin
        exp_state = S_WRITE; exp_wr_ack = 1'b1; exp_q.push_back(d);
      end
    end else if (!wr && rd) begin
      if (sz == 0) begin
        exp_state = S_RD_ERROR; exp_rd_err = 1'b1;
      end else begin
        exp_state = S_READ; exp_rd_ack = 1'b1; exp_rd_data = exp_q.pop_front();
      end
    end else begin
      if (sz == 0) begin
        exp_state = S_WRITE; exp_wr_ack = 1'b1; exp_rd_err = 1'b1; exp_q.push_back(d);
      end else begin
        exp_state = S_RDWR; exp_wr_ack = 1'b1; exp_rd_ack = 1'b1;
        exp_rd_data = exp_q.pop_front();
        exp_q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    step(1'b0, 1'b1, 32'h0, "pop_empty");

    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i * 32'h11), "fill");
    step(1'b1, 1'b0, 32'h99, "overflow");

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0, "drain");
    step(1'b0, 1'b0, 32'h0, "idle");

    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i * 32'h11), "refill");
    step(1'b1, 1'b1, 32'hAA, "rdwr_full");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0, "drain_aa");

    step(1'b1, 1'b1, 32'h5, "rdwr_empty");
    step(1'b0, 1'b1, 32'h0, "pop_5");

    // random traffic, biased toward alternating fill and drain phases
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 70 : 30;
      step(($urandom_range(99) < bias), ($urandom_range(99) >= bias), $urandom, "rand");
    end

    // reset in the middle of a stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, "pre_reset");
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 32'h0, "post_reset_pop");
    step(1'b1, 1'b0, 32'h1234, "post_reset_push");
    step(1'b0, 1'b1, 32'h0, "post_reset_read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
